// File: rtl/paddle_input.sv
// Paddle input conditioner: synchronises two raw pins into frame-stable move requests for the game stage.
// Button mode debounces and mutually excludes; quadrature mode accumulates encoder steps drained one per frame.
module paddle_input #(
  parameter int QUAD_MODE       = 0,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int ACC_W           = 6
) (
  input  logic clk25,
  input  logic reset,
  input  logic button_left_raw,
  input  logic button_right_raw,
  input  logic frame_tick,
  output logic button_left,
  output logic button_right,
  output logic left_press,
  output logic right_press
);
  // bit 0 = left pin (encoder A), bit 1 = right pin (encoder B)
  logic [1:0] meta;
  logic [1:0] sync;
  logic [1:0] press;
  logic       mv_l;
  logic       mv_r;

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {button_right_raw, button_left_raw};
      sync <= meta;
    end
  end

  generate
    if (QUAD_MODE == 0) begin : g_btn
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
      logic [1:0]       stable;
      logic [CNT_W-1:0] cnt [2];

      always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
          stable <= '0;
          press  <= '0;
          cnt[0] <= '0;
          cnt[1] <= '0;
        end else begin
          for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync[i] == stable[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              stable[i] <= sync[i];
              cnt[i]    <= '0;
              press[i]  <= sync[i];
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end

      // Both held cancels out so the paddle never gets contradictory requests
      always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
          mv_l <= 1'b0;
          mv_r <= 1'b0;
        end else if (frame_tick) begin
          mv_l <= stable[0] & ~stable[1];
          mv_r <= stable[1] & ~stable[0];
        end
      end
    end else begin : g_quad
      localparam logic signed [ACC_W+1:0] SAT_HI = (ACC_W+2)'(2**(ACC_W-1) - 1);
      localparam logic signed [ACC_W+1:0] SAT_LO = -SAT_HI;
      logic [1:0]              ab;
      logic [1:0]              prev;
      logic [1:0]              pos_now;
      logic [1:0]              pos_prev;
      logic [1:0]              delta;
      logic [1:0]              step;
      logic [1:0]              drain;
      logic signed [ACC_W-1:0] acc;
      logic signed [ACC_W-1:0] acc_nxt;
      logic signed [ACC_W+1:0] sum;
      logic                    acc_pos;
      logic                    acc_neg;

      assign ab       = {sync[0], sync[1]};
      // Gray-to-binary gives the phase; a difference of 2 is an invalid double-bit jump
      assign pos_now  = {ab[1], ab[1] ^ ab[0]};
      assign pos_prev = {prev[1], prev[1] ^ prev[0]};
      assign delta    = pos_now - pos_prev;
      assign acc_neg  = acc[ACC_W-1];
      assign acc_pos  = ~acc[ACC_W-1] & (acc != '0);
      assign press    = '0;

      always_comb begin
        step    = 2'b00;
        drain   = 2'b00;
        sum     = '0;
        acc_nxt = acc;
        if (delta == 2'd1) begin
          step = 2'b01;
        end else if (delta == 2'd3) begin
          step = 2'b11;
        end
        if (frame_tick && acc_pos) begin
          drain = 2'b11;
        end else if (frame_tick && acc_neg) begin
          drain = 2'b01;
        end
        sum = {{2{acc[ACC_W-1]}}, acc} + {{ACC_W{step[1]}}, step}
            + {{ACC_W{drain[1]}}, drain};
        if (sum > SAT_HI) begin
          acc_nxt = SAT_HI[ACC_W-1:0];
        end else if (sum < SAT_LO) begin
          acc_nxt = SAT_LO[ACC_W-1:0];
        end else begin
          acc_nxt = sum[ACC_W-1:0];
        end
      end

      always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
          prev <= '0;
          acc  <= '0;
          mv_l <= 1'b0;
          mv_r <= 1'b0;
        end else begin
          prev <= ab;
          acc  <= acc_nxt;
          if (frame_tick) begin
            mv_l <= acc_pos;
            mv_r <= acc_neg;
          end
        end
      end
    end
  endgenerate

  assign button_left  = mv_l;
  assign button_right = mv_r;
  assign left_press   = press[0];
  assign right_press  = press[1];
endmodule

// File: tb/tb_paddle_input.sv
// Bench for paddle_input: one instance in button mode (short debounce), one in quadrature mode.
module tb_paddle_input;
  logic clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  logic rst_b, rst_q;
  logic lraw_b, rraw_b, lraw_q, rraw_q;
  logic tick_b, tick_q;
  logic bl, br, lp, rp;
  logic ql, qr, qlp, qrp;

  int total = 0;
  int bad   = 0;

  paddle_input #(.QUAD_MODE(0), .DEBOUNCE_CYCLES(8), .CNT_W(4), .ACC_W(6)) u_btn (
    .clk25(clk25), .reset(rst_b), .button_left_raw(lraw_b), .button_right_raw(rraw_b),
    .frame_tick(tick_b), .button_left(bl), .button_right(br),
    .left_press(lp), .right_press(rp));

  paddle_input #(.QUAD_MODE(1), .DEBOUNCE_CYCLES(8), .CNT_W(4), .ACC_W(6)) u_quad (
    .clk25(clk25), .reset(rst_q), .button_left_raw(lraw_q), .button_right_raw(rraw_q),
    .frame_tick(tick_q), .button_left(ql), .button_right(qr),
    .left_press(qlp), .right_press(qrp));

  typedef struct packed { logic l; logic r; } mv_t;
  typedef struct { logic l; logic r; int hold; logic el; logic er; } bvec_t;
  typedef struct { logic [1:0] ab; bit tick; logic el; logic er; } qvec_t;

  mv_t   exp_q[$];
  bvec_t bv[$];
  qvec_t qv[$];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk25);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Raise frame_tick for one edge; expectation is queued, then popped once the move outputs update
  task automatic frame(input bit quad, input logic el, input logic er, input string nm);
    mv_t e;
    mv_t a;
    e.l = el;
    e.r = er;
    if (quad) tick_q = 1'b1; else tick_b = 1'b1;
    exp_q.push_back(e);
    cyc(1);
    tick_q = 1'b0;
    tick_b = 1'b0;
    a.l = quad ? ql : bl;
    a.r = quad ? qr : br;
    e = exp_q.pop_front();
    check({nm, ".left"}, 32'(a.l), 32'(e.l));
    check({nm, ".right"}, 32'(a.r), 32'(e.r));
  endtask

  task automatic qstep(input logic [1:0] ab);
    lraw_q = ab[1];
    rraw_q = ab[0];
    cyc(4);
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic add_b(input logic l, input logic r, input int h, input logic el, input logic er);
    bvec_t v;
    v.l = l; v.r = r; v.hold = h; v.el = el; v.er = er;
    bv.push_back(v);
  endtask

  task automatic add_q(input logic [1:0] ab, input bit t, input logic el, input logic er);
    qvec_t v;
    v.ab = ab; v.tick = t; v.el = el; v.er = er;
    qv.push_back(v);
  endtask

  initial begin
    int n;
    int at;
    logic [1:0] ab;

    add_b(1, 1, 12, 0, 0);
    add_b(1, 0, 10, 1, 0);
    add_b(0, 1, 12, 0, 1);
    add_b(0, 0, 12, 0, 0);
    add_b(1, 0, 12, 1, 0);
    add_b(0, 0, 5,  1, 0);
    add_b(0, 0, 12, 0, 0);
    add_b(0, 1, 12, 0, 1);
    add_b(1, 1, 4,  0, 1);
    add_b(1, 1, 12, 0, 0);
    add_b(1, 0, 12, 1, 0);

    add_q(2'b01, 0, 0, 0);
    add_q(2'b11, 0, 0, 0);
    add_q(2'b10, 0, 0, 0);
    add_q(2'b10, 1, 1, 0);
    add_q(2'b10, 1, 1, 0);
    add_q(2'b10, 1, 1, 0);
    add_q(2'b10, 1, 0, 0);
    add_q(2'b00, 0, 0, 0);
    add_q(2'b11, 0, 0, 0);
    add_q(2'b11, 1, 1, 0);
    add_q(2'b11, 1, 0, 0);
    add_q(2'b01, 0, 0, 0);
    add_q(2'b00, 0, 0, 0);
    add_q(2'b00, 1, 0, 1);
    add_q(2'b00, 1, 0, 1);
    add_q(2'b00, 1, 0, 0);

    rst_b = 1'b1; rst_q = 1'b1;
    lraw_b = 1'b0; rraw_b = 1'b0; lraw_q = 1'b0; rraw_q = 1'b0;
    tick_b = 1'b0; tick_q = 1'b0;
    cyc(3);
    check("reset.outs", 32'({bl, br, lp, rp, ql, qr, qlp, qrp}), 32'd0);
    rst_b = 1'b0; rst_q = 1'b0;
    cyc(2);

    // Left held: press pulse exactly once, 2 sync + 8 debounce cycles later
    lraw_b = 1'b1;
    n = 0; at = -1;
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      if (lp) begin n++; at = i; end
    end
    check("hold.press_count", 32'(n), 32'd1);
    check("hold.press_cycle", 32'(at), 32'd10);
    check("hold.no_tick_yet", 32'(bl), 32'd0);
    frame(0, 1, 0, "hold");
    lraw_b = 1'b0;
    cyc(5);
    frame(0, 1, 0, "rel_pending");
    cyc(10);
    frame(0, 0, 0, "rel_done");

    // Bounce every 3 cycles, then settle high
    n = 0;
    for (int k = 0; k < 14; k++) begin
      lraw_b = ~lraw_b;
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        if (lp) n++;
      end
    end
    check("bounce.no_press", 32'(n), 32'd0);
    lraw_b = 1'b1;
    n = 0; at = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (lp) begin n++; at = i; end
    end
    check("settle.press_count", 32'(n), 32'd1);
    check("settle.press_cycle", 32'(at), 32'd10);
    frame(0, 1, 0, "settle");

    foreach (bv[i]) begin
      lraw_b = bv[i].l;
      rraw_b = bv[i].r;
      cyc(bv[i].hold);
      frame(0, bv[i].el, bv[i].er, $sformatf("bvec%0d", i));
    end

    // Release left, then reset with the release half-debounced
    lraw_b = 1'b0;
    cyc(7);
    #5 rst_b = 1'b1;
    #1;
    check("btn_rst.async", 32'({bl, br, lp, rp}), 32'd0);
    cyc(2);
    rst_b = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (lp || rp) n++;
    end
    check("btn_rst.no_press", 32'(n), 32'd0);
    frame(0, 0, 0, "btn_rst.move");

    foreach (qv[i]) begin
      qstep(qv[i].ab);
      if (qv[i].tick) frame(1, qv[i].el, qv[i].er, $sformatf("qvec%0d", i));
    end

    // Saturation: 40 forward steps, 31 ticks of left then idle
    ab = 2'b00;
    for (int i = 0; i < 40; i++) begin
      ab = fwd(ab);
      qstep(ab);
    end
    check("quad.press_tied", 32'({qlp, qrp}), 32'd0);
    for (int k = 0; k < 32; k++) begin
      frame(1, (k < 31) ? 1'b1 : 1'b0, 1'b0, $sformatf("sat_tick%0d", k + 1));
    end

    // Step landing in the same cycle as the tick at acc=1
    ab = fwd(ab);
    qstep(ab);
    ab = fwd(ab);
    lraw_q = ab[1];
    rraw_q = ab[0];
    cyc(2);
    frame(1, 1, 0, "coin");
    cyc(2);
    frame(1, 1, 0, "coin_after");
    frame(1, 0, 0, "coin_drained");

    // Build acc=11, drain once to 10 with left asserted, then reset asynchronously
    for (int i = 0; i < 11; i++) begin
      ab = fwd(ab);
      qstep(ab);
    end
    frame(1, 1, 0, "pre_rst");
    #5 rst_q = 1'b1;
    #1;
    check("quad_rst.async", 32'({ql, qr}), 32'd0);
    lraw_q = 1'b0;
    rraw_q = 1'b0;
    cyc(2);
    rst_q = 1'b0;
    cyc(5);
    frame(1, 0, 0, "quad_rst.move");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
